// File: rtl/fma_mularb_if.sv
// fma_mularb_if
//   Bundles the two lane request/response channels and the shared multiplier
//   port of the FMA multiplier arbiter.
//
//   Lane X (X = 0, 1):
//     rX_valid  lane -> arb   beat request
//     rX_ready  arb -> lane   beat accepted this cycle
//     rX_last   lane -> arb   beat closes the transaction (0 holds the lock)
//     rX_a/b    lane -> arb   32-bit operands
//     rX_rvalid arb -> lane   one-cycle result strobe
//     rX_rdata  arb -> lane   64-bit product
//   Multiplier:
//     mul_en, mul_in_1, mul_in_2  arb -> mul
//     mul_out                     mul -> arb
//
//   slave  : the arbiter side
//   master : the lanes plus the multiplier unit
interface fma_mularb_if;
  logic        r0_valid;
  logic        r0_ready;
  logic        r0_last;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic        r0_rvalid;
  logic [63:0] r0_rdata;

  logic        r1_valid;
  logic        r1_ready;
  logic        r1_last;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic        r1_rvalid;
  logic [63:0] r1_rdata;

  logic        mul_en;
  logic [31:0] mul_in_1;
  logic [31:0] mul_in_2;
  logic [63:0] mul_out;

  modport slave (
    input  r0_valid, r0_last, r0_a, r0_b,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_last, r1_a, r1_b,
    output r1_ready, r1_rvalid, r1_rdata,
    output mul_en, mul_in_1, mul_in_2,
    input  mul_out
  );

  modport master (
    output r0_valid, r0_last, r0_a, r0_b,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_last, r1_a, r1_b,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mul_en, mul_in_1, mul_in_2,
    output mul_out
  );
endinterface

// File: rtl/fma_mularb.sv
// fma_mularb
//   Round-robin arbiter that shares one 32x32 multiplier between two FMA
//   lanes. A lane can lock the multiplier for a multi-beat burst by sending
//   beats with last=0. Products come back to the issuing lane MUL_LAT+1
//   cycles after acceptance, steered by a tag pipeline that shadows the
//   multiplier's latency.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    fma_mularb_if.slave: lane channels and multiplier port
//     busy   high while a lock is held or any result is still in flight
//
//   Parameters:
//     MUL_LAT  multiplier latency in cycles (>= 1)
module fma_mularb #(
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  fma_mularb_if.slave  bus,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic [MUL_LAT:0]    tagValid_q;
  logic [MUL_LAT:0]    tagId_q;
  logic                rvalid0_q, rvalid1_q;
  logic [63:0]         rdata0_q, rdata1_q;

  logic                ready0, ready1;
  logic                issue0, issue1;

  // Grant decision. Readies are forced low while reset is asserted so a
  // lane cannot see an acceptance the state registers never recorded.
  // In IDLE the prio bit only matters when both lanes ask at once; a lock
  // owner is ready even when it has nothing to send, which keeps the other
  // lane parked for the whole burst.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          ready0 = bus.r0_valid && (!bus.r1_valid || !prio_q);
          ready1 = bus.r1_valid && (!bus.r0_valid ||  prio_q);
        end
        LOCK0:   ready0 = 1'b1;
        LOCK1:   ready1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign issue0 = bus.r0_valid && ready0;
  assign issue1 = bus.r1_valid && ready1;

  assign bus.r0_ready = ready0;
  assign bus.r1_ready = ready1;

  // The multiplier is driven straight from the winning lane; idle cycles
  // present zero operands.
  assign bus.mul_en   = issue0 || issue1;
  assign bus.mul_in_1 = issue0 ? bus.r0_a : (issue1 ? bus.r1_a : 32'd0);
  assign bus.mul_in_2 = issue0 ? bus.r0_b : (issue1 ? bus.r1_b : 32'd0);

  // Lock and priority next state. A closing beat (last=1) always hands
  // priority to the other lane; an opening beat keeps priority so the
  // round-robin order resumes where it left off once the burst ends.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (issue0) begin
      if (bus.r0_last) begin
        state_d = IDLE;
        prio_d  = 1'b1;
      end else begin
        state_d = LOCK0;
      end
    end else if (issue1) begin
      if (bus.r1_last) begin
        state_d = IDLE;
        prio_d  = 1'b0;
      end else begin
        state_d = LOCK1;
      end
    end
  end

  // State, tag pipeline and result registers. Tag stage k holds the beat
  // issued k+1 cycles ago, so stage MUL_LAT-1 lines up with the cycle in
  // which mul_out carries that beat's product. The final stage only keeps
  // busy high through the result strobe cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      tagValid_q <= '0;
      tagId_q    <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 64'd0;
      rdata1_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      tagValid_q <= {tagValid_q[MUL_LAT-1:0], issue0 || issue1};
      tagId_q    <= {tagId_q[MUL_LAT-1:0], issue1};
      rvalid0_q  <= tagValid_q[MUL_LAT-1] && !tagId_q[MUL_LAT-1];
      rvalid1_q  <= tagValid_q[MUL_LAT-1] &&  tagId_q[MUL_LAT-1];
      if (tagValid_q[MUL_LAT-1] && !tagId_q[MUL_LAT-1]) begin
        rdata0_q <= bus.mul_out;
      end
      if (tagValid_q[MUL_LAT-1] && tagId_q[MUL_LAT-1]) begin
        rdata1_q <= bus.mul_out;
      end
    end
  end

  assign bus.r0_rvalid = rvalid0_q;
  assign bus.r1_rvalid = rvalid1_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;

  assign busy = (state_q != IDLE) || (|tagValid_q);

endmodule

// File: tb/tb_fma_mularb.sv
// tb_fma_mularb
//   Directed bench for fma_mularb with a behavioural MUL_LAT-cycle
//   multiplier. Accepted beats push their expected product and arrival
//   cycle into a per-lane queue; a negedge monitor pops and compares.
module tb_fma_mularb;

  localparam int MUL_LAT = 3;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;
  int   cyc;
  int   testCount;
  int   failCount;
  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] mulPipe [0:MUL_LAT-1];

  fma_mularb_if bus ();

  fma_mularb #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: fixed latency, never reset, so stale products
  // stay on mul_out across a reset.
  always @(posedge clk) begin
    mulPipe[0] <= {32'd0, bus.mul_in_1} * {32'd0, bus.mul_in_2};
    for (int i = 1; i < MUL_LAT; i++) mulPipe[i] <= mulPipe[i-1];
  end
  assign bus.mul_out = mulPipe[MUL_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  // Result monitor: each lane strobes exactly when its queue head is due.
  always @(negedge clk) begin
    if (q0.size() > 0 && q0[0].due == cyc) begin
      checkOutput("r0_rvalid", {63'd0, bus.r0_rvalid}, 64'd1);
      checkOutput("r0_rdata", bus.r0_rdata, q0[0].data);
      void'(q0.pop_front());
    end else begin
      checkOutput("r0_rvalid_quiet", {63'd0, bus.r0_rvalid}, 64'd0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      checkOutput("r1_rvalid", {63'd0, bus.r1_rvalid}, 64'd1);
      checkOutput("r1_rdata", bus.r1_rdata, q1[0].data);
      void'(q1.pop_front());
    end else begin
      checkOutput("r1_rvalid_quiet", {63'd0, bus.r1_rvalid}, 64'd0);
    end
  end

  // One cycle of lane stimulus. e0/e1 are the expected readies; expBusy of
  // -1 skips the busy check. Entered and left 1ns after a rising edge.
  task automatic applyStimulus(input string tag,
                               input logic v0, input logic l0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic l1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic e0, input logic e1, input int expBusy);
    logic        acc0, acc1;
    logic [31:0] expIn1, expIn2;
    exp_t        item;
    bus.r0_valid = v0;
    bus.r0_last  = l0;
    bus.r0_a     = a0;
    bus.r0_b     = b0;
    bus.r1_valid = v1;
    bus.r1_last  = l1;
    bus.r1_a     = a1;
    bus.r1_b     = b1;
    acc0   = v0 && e0;
    acc1   = v1 && e1;
    expIn1 = acc0 ? a0 : (acc1 ? a1 : 32'd0);
    expIn2 = acc0 ? b0 : (acc1 ? b1 : 32'd0);
    @(negedge clk);
    checkOutput({tag, ".r0_ready"}, {63'd0, bus.r0_ready}, {63'd0, e0});
    checkOutput({tag, ".r1_ready"}, {63'd0, bus.r1_ready}, {63'd0, e1});
    checkOutput({tag, ".mul_en"}, {63'd0, bus.mul_en}, {63'd0, acc0 || acc1});
    checkOutput({tag, ".mul_in_1"}, {32'd0, bus.mul_in_1}, {32'd0, expIn1});
    checkOutput({tag, ".mul_in_2"}, {32'd0, bus.mul_in_2}, {32'd0, expIn2});
    if (expBusy >= 0) checkOutput({tag, ".busy"}, {63'd0, busy}, (expBusy != 0) ? 64'd1 : 64'd0);
    if (acc0) begin
      item.due  = cyc + MUL_LAT + 1;
      item.data = {32'd0, a0} * {32'd0, b0};
      q0.push_back(item);
    end
    if (acc1) begin
      item.due  = cyc + MUL_LAT + 1;
      item.data = {32'd0, a1} * {32'd0, b1};
      q1.push_back(item);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus("idle", 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, -1);
  endtask

  // Holds reset low for one cycle with both lanes requesting; in-flight
  // expectations are discarded because the design drops them.
  task automatic applyReset();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    bus.r0_valid = 1'b1;
    bus.r0_last  = 1'b1;
    bus.r0_a     = 32'd9;
    bus.r0_b     = 32'd9;
    bus.r1_valid = 1'b1;
    bus.r1_last  = 1'b1;
    bus.r1_a     = 32'd7;
    bus.r1_b     = 32'd7;
    @(negedge clk);
    checkOutput("rst.r0_ready", {63'd0, bus.r0_ready}, 64'd0);
    checkOutput("rst.r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    checkOutput("rst.mul_en", {63'd0, bus.mul_en}, 64'd0);
    checkOutput("rst.mul_in_1", {32'd0, bus.mul_in_1}, 64'd0);
    checkOutput("rst.mul_in_2", {32'd0, bus.mul_in_2}, 64'd0);
    checkOutput("rst.busy", {63'd0, busy}, 64'd0);
    checkOutput("rst.r0_rdata", bus.r0_rdata, 64'd0);
    checkOutput("rst.r1_rdata", bus.r1_rdata, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    reset     = 1'b0;
    bus.r0_valid = 1'b0;
    bus.r0_last  = 1'b1;
    bus.r0_a     = 32'd0;
    bus.r0_b     = 32'd0;
    bus.r1_valid = 1'b0;
    bus.r1_last  = 1'b1;
    bus.r1_a     = 32'd0;
    bus.r1_b     = 32'd0;
    #1;

    // Reset state with both lanes requesting.
    applyReset();

    // Single beat 3*5 from lane 0; busy covers the flight and the strobe.
    applyStimulus("single", 1'b1, 1'b1, 32'd3, 32'd5, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, 0);
    applyStimulus("flight1", 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    applyStimulus("flight2", 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    applyStimulus("flight3", 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    applyStimulus("strobe", 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    applyStimulus("drained", 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 0);

    // Contention right after reset: strict alternation starting at lane 0.
    applyReset();
    for (int i = 0; i < 6; i++)
      applyStimulus("contend", 1'b1, 1'b1, 32'(i + 1), 32'(i + 2), 1'b1, 1'b1, 32'(i + 11), 32'(i + 12),
                    (i % 2) == 0, (i % 2) == 1, -1);
    applyIdle(5);

    // Lane 0 four-beat burst with a valid gap; lane 1 waits throughout and
    // wins the very next cycle after the closing beat.
    applyStimulus("lock.b1", 1'b1, 1'b0, 32'd10, 32'd11, 1'b1, 1'b1, 32'd20, 32'd21, 1'b1, 1'b0, -1);
    applyStimulus("lock.b2", 1'b1, 1'b0, 32'd12, 32'd13, 1'b1, 1'b1, 32'd20, 32'd21, 1'b1, 1'b0, 1);
    applyStimulus("lock.gap", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd20, 32'd21, 1'b1, 1'b0, 1);
    applyStimulus("lock.b3", 1'b1, 1'b0, 32'd14, 32'd15, 1'b1, 1'b1, 32'd20, 32'd21, 1'b1, 1'b0, -1);
    applyStimulus("lock.b4", 1'b1, 1'b1, 32'd16, 32'd17, 1'b1, 1'b1, 32'd20, 32'd21, 1'b1, 1'b0, -1);
    applyStimulus("lock.r1", 1'b1, 1'b1, 32'd1, 32'd2, 1'b1, 1'b1, 32'd20, 32'd21, 1'b0, 1'b1, -1);
    applyStimulus("lock.r0", 1'b1, 1'b1, 32'd1, 32'd2, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, -1);
    applyIdle(5);

    // Full-width unsigned product from lane 1.
    applyStimulus("fullwidth", 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, -1);
    applyIdle(5);
    checkOutput("fullwidth.r1_rdata", bus.r1_rdata, 64'hFFFF_FFFE_0000_0001);

    // Back-to-back alternating beats with distinct operands.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0)
        applyStimulus("route", 1'b1, 1'b1, 32'(i + 100), 32'(i * 3 + 7), 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, -1);
      else
        applyStimulus("route", 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b1, 32'(i + 200), 32'(i * 5 + 9), 1'b0, 1'b1, -1);
    end
    applyIdle(5);

    // Reset while lane 0 holds the lock with two beats in flight.
    applyStimulus("mid.b1", 1'b1, 1'b0, 32'd3, 32'd4, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0, -1);
    applyStimulus("mid.b2", 1'b1, 1'b0, 32'd5, 32'd6, 1'b1, 1'b1, 32'd8, 32'd8, 1'b1, 1'b0, 1);
    applyReset();
    applyStimulus("mid.post", 1'b1, 1'b1, 32'd21, 32'd22, 1'b1, 1'b1, 32'd31, 32'd32, 1'b1, 1'b0, 0);
    applyIdle(6);

    checkOutput("end.q0_empty", 64'(q0.size()), 64'd0);
    checkOutput("end.q1_empty", 64'(q1.size()), 64'd0);
    checkOutput("end.busy", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/fma_mularb.md
# fma_mularb

Round-robin arbiter and sequencer that shares one 32x32 multiplier unit (`mul`, with `mulit`/`mulot` signals en, req_in_1, req_in_2 and out) between the two FMA lanes. Each lane issues partial-product beats through a valid/ready handshake. A lane may lock the multiplier for a multi-beat burst, for example the four partial products of a 53-bit mantissa. Results return to the issuing lane after the multiplier's fixed latency, routed by an internal tag pipeline.

## Interface
Parameters:
- MUL_LAT, default 3: multiplier latency in cycles, ≥1. mul_out holds the product MUL_LAT cycles after the cycle in which mul_en was high.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_valid  in  1  lane 0 beat request.
- r0_ready  out  1  lane 0 beat accepted this cycle (combinational).
- r0_last  in  1  beat ends the lane 0 transaction; 0 requests the lock.
- r0_a, r0_b  in  32 each  lane 0 operands.
- r0_rvalid  out  1  lane 0 result strobe.
- r0_rdata  out  64  lane 0 product.
- r1_valid, r1_ready, r1_last, r1_a, r1_b, r1_rvalid, r1_rdata: same as lane 0, for lane 1.
- mul_en  out  1  multiplier issue strobe.
- mul_in_1, mul_in_2  out  32 each  multiplier operands.
- mul_out  in  64  multiplier product.
- busy  out  1  high when state≠IDLE or any tag is in flight.

## Operation
- Lock state register: IDLE, LOCK0, LOCK1. The priority bit `prio` and the tag pipeline are separate registers.
- Issue is combinational.
  - When rX_valid and rX_ready are both high: mul_en=1, mul_in_1=rX_a, mul_in_2=rX_b.
  - Otherwise mul_en=0 and mul_in_1=mul_in_2=0.
- IDLE:
  - Only one lane valid: that lane gets ready=1.
  - Both lanes valid: the lane named by prio gets ready; the other lane's ready=0.
  - Accepted beat with last=1: stay in IDLE; prio ← other lane.
  - Accepted beat with last=0: go to LOCKx, where x is the accepted lane; prio unchanged.
- LOCKx:
  - rx_ready=1 and the other lane's ready=0, regardless of valid.
  - Cycles where lock owner's valid is low are allowed: no issue that cycle, lock held.
  - Accepted beat with last=1: go to IDLE; prio ← other lane.
  - Accepted beat with last=0: stay in LOCKx.
- At most one beat is issued per cycle; peak throughput is 1 beat per cycle.
- Tag pipeline is MUL_LAT+1 stages of {v, id}.
  - Stage 0 captures {issue, lane id} each cycle.
  - When the stage-MUL_LAT-1 tag is valid, mul_out is registered into rdata of lane `id`, and rvalid of that lane is set for one cycle.
  - The other lane's rvalid is 0 that cycle; its rdata holds its last value.
- Products are unsigned 32x32→64 bits, passed through without modification; the arbiter does no arithmetic.
- There is no response backpressure: lanes must accept rvalid whenever it is asserted.

## Timing
- Reset (asynchronous, while reset=0):
  - state=IDLE, prio=lane 0, all tag valids 0.
  - r0_rvalid=r1_rvalid=0, r0_rdata=r1_rdata=0, busy=0.
  - Outputs mul_en=0, mul_in_1=mul_in_2=0 and r0_ready=r1_ready=0 (valids ignored during reset).
- Latency: a beat accepted in cycle c has its rvalid high and rdata valid in cycle c+MUL_LAT+1.
- Simultaneous requests in IDLE: exactly one ready per cycle, never both.
- Reset during a burst or with beats in flight:
  - Lock released, in-flight results discarded.
  - No rvalid after reset is released, even if mul_out still carries old products.
- After a last=1 beat in LOCKx, the other lane may be granted in the very next cycle; there is no dead cycle.
- busy falls in the cycle after the last in-flight result's rvalid, provided state=IDLE.

## Test plan
- Single beat, MUL_LAT=3: r0 sends a=3, b=5, last=1, accepted in cycle c → r0_rvalid=1 and r0_rdata=15 in cycle c+4 only; r1_rvalid stays 0.
- Contention: both lanes hold valid with last=1 for 6 cycles after reset → grants go 0,1,0,1,0,1, one mul_en per cycle, each result routed to the correct lane 4 cycles later.
- Lock: r0 sends a 4-beat burst (last on beat 4) with a 1-cycle valid gap while r1 is valid throughout → r1_ready=0 until beat 4 is accepted, r1 is granted the next cycle, and r0 receives 4 results in order.
- Full-width product: a=b=0xFFFFFFFF from r1 → r1_rdata=0xFFFFFFFE00000001.
- Reset mid-flight: drop reset with 2 beats in the pipeline and r0 locked → rvalid stays 0 on both lanes afterward, busy=0, and the first post-reset conflict is granted to r0.
- Pipelined routing: r0 and r1 beats alternate for 10 cycles with distinct operands → every lane receives exactly its own products, in issue order, each at c+MUL_LAT+1.
